// File: rtl/cs_reg_file_pkg.sv
// Shared CSR definitions for the machine-mode CSR file: addresses, ALU CSR ops, WARL masks, cause codes.
// CERES_USER_COUNTERS_EN adds the read-only user counter aliases to is_supported_csr().
package cs_reg_file_pkg;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
        OP_CSRRW, OP_CSRRS, OP_CSRRC, OP_CSRRWI, OP_CSRRSI, OP_CSRRCI
    } alu_op_e;

    typedef enum logic [1:0] {
        MTVEC_DIRECT   = 2'd0,
        MTVEC_VECTORED = 2'd1
    } mtvec_mode_e;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_TIME      = 12'hC01;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_TIMEH     = 12'hC81;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;

    localparam int unsigned IRQ_MSI = 3;
    localparam int unsigned IRQ_MTI = 7;
    localparam int unsigned IRQ_MEI = 11;

    localparam logic [31:0] MIE_MASK = (32'd1 << IRQ_MSI) | (32'd1 << IRQ_MTI) | (32'd1 << IRQ_MEI);

    function automatic logic is_supported_csr(input logic [11:0] addr);
        logic ok;
        case (addr)
            CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
            CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MINSTRET,
            CSR_MCYCLEH, CSR_MINSTRETH, CSR_MHARTID: ok = 1'b1;
`ifdef CERES_USER_COUNTERS_EN
            CSR_CYCLE, CSR_TIME, CSR_INSTRET,
            CSR_CYCLEH, CSR_TIMEH, CSR_INSTRETH:      ok = 1'b1;
`endif
            default:                                   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/cs_reg_file_counter64.sv
// 64-bit counter with per-half load; a load in either half suppresses increment and carry that cycle.
module cs_counter64 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] value_o
);

    logic [31:0] lo_q, lo_d, hi_q, hi_d;
    logic        carry;

    always_comb begin
        lo_d  = lo_q;
        hi_d  = hi_q;
        carry = 1'b0;
        if (wr_lo_i || wr_hi_i) begin
            if (wr_lo_i) lo_d = wdata_i;
            if (wr_hi_i) hi_d = wdata_i;
        end else if (inc_i) begin
            {carry, lo_d} = {1'b0, lo_q} + 33'd1;
            hi_d          = hi_q + {31'd0, carry};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

    assign value_o = {hi_q, lo_q};

endmodule

// File: rtl/cs_reg_file.sv
// Machine-mode CSR file: CSR read/modify/write, trap entry / mret, interrupt pending and cycle/instret.
// CERES_USER_COUNTERS_EN enables the read-only user counter aliases (cycle/time/instret and high halves).
module cs_reg_file
    import cs_reg_file_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h8000_0000,
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_1100
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        rd_en_i,
    input  logic        wr_en_i,
    input  logic [11:0] csr_idx_i,
    input  alu_op_e     alu_ctrl_i,
    input  logic [31:0] csr_wdata_i,
    output logic [31:0] csr_rdata_o,
    input  logic        trap_active_i,
    input  logic [31:0] trap_cause_i,
    input  logic [31:0] trap_pc_i,
    input  logic [31:0] trap_tval_i,
    input  logic        mret_i,
    input  logic        retire_i,
    input  logic        irq_ext_i,
    input  logic        irq_tim_i,
    input  logic        irq_sw_i,
    output logic [31:0] trap_target_o,
    output logic [31:0] mepc_o,
    output logic        irq_pending_o,
    output logic [31:0] irq_cause_o
);

    logic        mstatus_mie_q, mstatus_mie_d, mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
    logic [31:0] mstatus_rd, mip_rd, csr_old, csr_new, irq_active;
    logic        csr_op, wr_commit, trap_fire, mret_fire;
    logic [1:0]  cnt_inc, cnt_wr_lo, cnt_wr_hi;
    logic [63:0] cnt_val [2];

    // MPP is hardwired to machine mode.
    always_comb begin
        mstatus_rd                   = 32'h0000_1800;
        mstatus_rd[MSTATUS_MIE_BIT]  = mstatus_mie_q;
        mstatus_rd[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
        mip_rd                       = '0;
        mip_rd[IRQ_MSI]              = irq_sw_i;
        mip_rd[IRQ_MTI]              = irq_tim_i;
        mip_rd[IRQ_MEI]              = irq_ext_i;
    end

    always_comb begin
        case (csr_idx_i)
            CSR_MSTATUS:   csr_old = mstatus_rd;
            CSR_MISA:      csr_old = MISA_VALUE;
            CSR_MIE:       csr_old = mie_q;
            CSR_MTVEC:     csr_old = mtvec_q;
            CSR_MSCRATCH:  csr_old = mscratch_q;
            CSR_MEPC:      csr_old = mepc_q;
            CSR_MCAUSE:    csr_old = mcause_q;
            CSR_MTVAL:     csr_old = mtval_q;
            CSR_MIP:       csr_old = mip_rd;
            CSR_MCYCLE:    csr_old = cnt_val[0][31:0];
            CSR_MCYCLEH:   csr_old = cnt_val[0][63:32];
            CSR_MINSTRET:  csr_old = cnt_val[1][31:0];
            CSR_MINSTRETH: csr_old = cnt_val[1][63:32];
            CSR_MHARTID:   csr_old = HART_ID;
`ifdef CERES_USER_COUNTERS_EN
            CSR_CYCLE, CSR_TIME:   csr_old = cnt_val[0][31:0];
            CSR_CYCLEH, CSR_TIMEH: csr_old = cnt_val[0][63:32];
            CSR_INSTRET:           csr_old = cnt_val[1][31:0];
            CSR_INSTRETH:          csr_old = cnt_val[1][63:32];
`endif
            default:       csr_old = '0;
        endcase
    end

    assign csr_rdata_o = rd_en_i ? csr_old : 32'd0;

    always_comb begin
        csr_op  = 1'b1;
        csr_new = csr_wdata_i;
        case (alu_ctrl_i)
            OP_CSRRW, OP_CSRRWI: csr_new = csr_wdata_i;
            OP_CSRRS, OP_CSRRSI: csr_new = csr_old | csr_wdata_i;
            OP_CSRRC, OP_CSRRCI: csr_new = csr_old & ~csr_wdata_i;
            default:             csr_op  = 1'b0;
        endcase
    end

    assign trap_fire = trap_active_i && !stall_i;
    assign mret_fire = mret_i && !trap_active_i && !stall_i;
    assign wr_commit = wr_en_i && csr_op && !stall_i && !trap_active_i && !mret_i
                       && is_supported_csr(csr_idx_i);

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        if (trap_fire) begin
            mepc_d         = trap_pc_i & ~32'd3;
            mcause_d       = trap_cause_i;
            mtval_d        = trap_tval_i;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret_fire) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (wr_commit) begin
            case (csr_idx_i)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = csr_new[MSTATUS_MIE_BIT];
                    mstatus_mpie_d = csr_new[MSTATUS_MPIE_BIT];
                end
                CSR_MIE:      mie_d      = csr_new & MIE_MASK;
                CSR_MTVEC:    mtvec_d    = csr_new & ~32'd2;
                CSR_MSCRATCH: mscratch_d = csr_new;
                CSR_MEPC:     mepc_d     = csr_new & ~32'd3;
                CSR_MCAUSE:   mcause_d   = csr_new;
                CSR_MTVAL:    mtval_d    = csr_new;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= MTVEC_RESET;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
        end
    end

    // Index 0 is mcycle (always counting), index 1 is minstret.
    assign cnt_inc      = {retire_i, 1'b1};
    assign cnt_wr_lo[0] = wr_commit && (csr_idx_i == CSR_MCYCLE);
    assign cnt_wr_hi[0] = wr_commit && (csr_idx_i == CSR_MCYCLEH);
    assign cnt_wr_lo[1] = wr_commit && (csr_idx_i == CSR_MINSTRET);
    assign cnt_wr_hi[1] = wr_commit && (csr_idx_i == CSR_MINSTRETH);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            cs_counter64 u_cnt (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .inc_i   (cnt_inc[gi]),
                .wr_lo_i (cnt_wr_lo[gi]),
                .wr_hi_i (cnt_wr_hi[gi]),
                .wdata_i (csr_new),
                .value_o (cnt_val[gi])
            );
        end
    endgenerate

    always_comb begin
        trap_target_o = {mtvec_q[31:2], 2'b00};
        if (mtvec_mode_e'({1'b0, mtvec_q[0]}) == MTVEC_VECTORED && trap_cause_i[31])
            trap_target_o = {mtvec_q[31:2], 2'b00} + {25'd0, trap_cause_i[4:0], 2'b00};
    end

    assign mepc_o        = mepc_q;
    assign irq_active    = mstatus_mie_q ? (mip_rd & mie_q) : 32'd0;
    assign irq_pending_o = |irq_active;

    always_comb begin
        irq_cause_o = '0;
        if (irq_active[IRQ_MEI])      irq_cause_o = 32'h8000_0000 | IRQ_MEI;
        else if (irq_active[IRQ_MSI]) irq_cause_o = 32'h8000_0000 | IRQ_MSI;
        else if (irq_active[IRQ_MTI]) irq_cause_o = 32'h8000_0000 | IRQ_MTI;
    end

endmodule

// File: tb/tb_cs_reg_file.sv
// Self-checking bench for cs_reg_file: vector table of CSR accesses plus trap/irq/counter sequences.
module tb_cs_reg_file;
    import cs_reg_file_pkg::*;

    logic        clk, rst, stall, rd_en, wr_en, trap_active, mret, retire;
    logic        irq_ext, irq_tim, irq_sw, irq_pending;
    logic [11:0] csr_idx;
    alu_op_e     alu_ctrl;
    logic [31:0] csr_wdata, csr_rdata, trap_cause, trap_pc, trap_tval;
    logic [31:0] trap_target, mepc, irq_cause;

    int          n_vec  = 0;
    int          n_fail = 0;
    logic [31:0] exp_q [$];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [11:0] idx;
        alu_op_e     op;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [27];

    cs_reg_file dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .stall_i       (stall),
        .rd_en_i       (rd_en),
        .wr_en_i       (wr_en),
        .csr_idx_i     (csr_idx),
        .alu_ctrl_i    (alu_ctrl),
        .csr_wdata_i   (csr_wdata),
        .csr_rdata_o   (csr_rdata),
        .trap_active_i (trap_active),
        .trap_cause_i  (trap_cause),
        .trap_pc_i     (trap_pc),
        .trap_tval_i   (trap_tval),
        .mret_i        (mret),
        .retire_i      (retire),
        .irq_ext_i     (irq_ext),
        .irq_tim_i     (irq_tim),
        .irq_sw_i      (irq_sw),
        .trap_target_o (trap_target),
        .mepc_o        (mepc),
        .irq_pending_o (irq_pending),
        .irq_cause_o   (irq_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one CSR access for a full cycle; expected rdata goes through the scoreboard queue.
    task automatic csr(input logic rd, input logic wr, input logic [11:0] idx, input alu_op_e op,
                       input logic [31:0] wd, input logic [31:0] exp, input string name);
        logic [31:0] e;
        rd_en = rd; wr_en = wr; csr_idx = idx; alu_ctrl = op; csr_wdata = wd;
        exp_q.push_back(exp);
        @(negedge clk);
        e = exp_q.pop_front();
        n_vec++;
        if (csr_rdata !== e) begin
            n_fail++;
            $display("FAIL %s: csr %h rdata=%h expected=%h", name, idx, csr_rdata, e);
        end else begin
            $display("ok   %s: csr %h rdata=%h", name, idx, csr_rdata);
        end
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0; alu_ctrl = OP_ADD; csr_wdata = '0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] user_exp;
        rst = 1'b1; stall = 1'b0; rd_en = 1'b0; wr_en = 1'b0; trap_active = 1'b0; mret = 1'b0;
        retire = 1'b0; irq_ext = 1'b0; irq_tim = 1'b0; irq_sw = 1'b0; csr_idx = '0;
        alu_ctrl = OP_ADD; csr_wdata = '0; trap_cause = '0; trap_pc = '0; trap_tval = '0;

        vecs[0]  = '{1'b1, 1'b0, CSR_MSTATUS,  OP_CSRRS, 32'h0,          32'h0000_1800};
        vecs[1]  = '{1'b1, 1'b0, CSR_MTVEC,    OP_CSRRS, 32'h0,          32'h8000_0000};
        vecs[2]  = '{1'b1, 1'b0, CSR_MISA,     OP_CSRRS, 32'h0,          32'h4000_1100};
        vecs[3]  = '{1'b1, 1'b0, CSR_MHARTID,  OP_CSRRS, 32'h0,          32'h0};
        vecs[4]  = '{1'b1, 1'b0, CSR_MIE,      OP_CSRRS, 32'h0,          32'h0};
        vecs[5]  = '{1'b1, 1'b1, CSR_MSCRATCH, OP_CSRRW, 32'hDEAD_BEEF,  32'h0};
        vecs[6]  = '{1'b1, 1'b0, CSR_MSCRATCH, OP_CSRRS, 32'h0,          32'hDEAD_BEEF};
        vecs[7]  = '{1'b1, 1'b1, CSR_MSCRATCH, OP_CSRRC, 32'hFFFF_0000,  32'hDEAD_BEEF};
        vecs[8]  = '{1'b1, 1'b0, CSR_MSCRATCH, OP_CSRRS, 32'h0,          32'h0000_BEEF};
        vecs[9]  = '{1'b1, 1'b1, CSR_MIE,      OP_CSRRW, 32'hFFFF_FFFF,  32'h0};
        vecs[10] = '{1'b1, 1'b0, CSR_MIE,      OP_CSRRS, 32'h0,          32'h0000_0888};
        vecs[11] = '{1'b1, 1'b1, CSR_MTVEC,    OP_CSRRW, 32'hFFFF_FFFF,  32'h8000_0000};
        vecs[12] = '{1'b1, 1'b0, CSR_MTVEC,    OP_CSRRS, 32'h0,          32'hFFFF_FFFD};
        vecs[13] = '{1'b1, 1'b1, CSR_MEPC,     OP_CSRRW, 32'h1234_5677,  32'h0};
        vecs[14] = '{1'b1, 1'b0, CSR_MEPC,     OP_CSRRS, 32'h0,          32'h1234_5674};
        vecs[15] = '{1'b1, 1'b1, CSR_MISA,     OP_CSRRW, 32'h0,          32'h4000_1100};
        vecs[16] = '{1'b1, 1'b0, CSR_MISA,     OP_CSRRS, 32'h0,          32'h4000_1100};
        vecs[17] = '{1'b1, 1'b1, CSR_MSTATUS,  OP_CSRRWI, 32'hFFFF_FFFF, 32'h0000_1800};
        vecs[18] = '{1'b1, 1'b0, CSR_MSTATUS,  OP_CSRRS, 32'h0,          32'h0000_1888};
        vecs[19] = '{1'b1, 1'b1, CSR_MSTATUS,  OP_CSRRW, 32'h0,          32'h0000_1888};
        vecs[20] = '{1'b1, 1'b0, 12'h7C0,      OP_CSRRS, 32'h0,          32'h0};
        vecs[21] = '{1'b0, 1'b0, CSR_MSCRATCH, OP_CSRRS, 32'h0,          32'h0};
        vecs[22] = '{1'b1, 1'b1, CSR_MSCRATCH, OP_ADD,   32'h1,          32'h0000_BEEF};
        vecs[23] = '{1'b1, 1'b0, CSR_MSCRATCH, OP_CSRRS, 32'h0,          32'h0000_BEEF};
        vecs[24] = '{1'b1, 1'b1, CSR_MHARTID,  OP_CSRRW, 32'h5,          32'h0};
        vecs[25] = '{1'b1, 1'b0, CSR_MHARTID,  OP_CSRRS, 32'h0,          32'h0};
        vecs[26] = '{1'b1, 1'b0, CSR_MIP,      OP_CSRRS, 32'h0,          32'h0};

        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        chk("reset_mepc", mepc, 32'h0);
        chk("reset_irq_pending", {31'd0, irq_pending}, 32'h0);

        for (int i = 0; i < 27; i++)
            csr(vecs[i].rd, vecs[i].wr, vecs[i].idx, vecs[i].op, vecs[i].wdata, vecs[i].exp,
                $sformatf("vec%0d", i));

        // Trap entry into a vectored handler; the concurrent mscratch write must be dropped.
        csr(1, 1, CSR_MTVEC, OP_CSRRW, 32'h8000_0101, 32'hFFFF_FFFD, "mtvec_vec");
        csr(1, 1, CSR_MSTATUS, OP_CSRRSI, 32'h8, 32'h0000_1800, "set_mie");
        trap_cause = 32'h0000_0002;
        csr(1, 0, CSR_MTVEC, OP_CSRRS, 32'h0, 32'h8000_0101, "mtvec_rd");
        chk("target_exc", trap_target, 32'h8000_0100);
        trap_active = 1'b1; trap_cause = 32'h8000_0007; trap_pc = 32'h0000_2003; trap_tval = 32'h55;
        csr(1, 1, CSR_MSCRATCH, OP_CSRRW, 32'h0000_1111, 32'h0000_BEEF, "trap_wr");
        chk("target_irq", trap_target, 32'h8000_011C);
        trap_active = 1'b0;
        chk("trap_mepc", mepc, 32'h0000_2000);
        csr(1, 0, CSR_MCAUSE, OP_CSRRS, 32'h0, 32'h8000_0007, "mcause");
        csr(1, 0, CSR_MTVAL, OP_CSRRS, 32'h0, 32'h0000_0055, "mtval");
        csr(1, 0, CSR_MSTATUS, OP_CSRRS, 32'h0, 32'h0000_1880, "trap_mstatus");
        csr(1, 0, CSR_MSCRATCH, OP_CSRRS, 32'h0, 32'h0000_BEEF, "trap_scratch");
        mret = 1'b1;
        csr(1, 0, CSR_MSTATUS, OP_CSRRS, 32'h0, 32'h0000_1880, "mret_cyc");
        mret = 1'b0;
        csr(1, 0, CSR_MSTATUS, OP_CSRRS, 32'h0, 32'h0000_1888, "mret_mstatus");
        stall = 1'b1;
        csr(1, 1, CSR_MSCRATCH, OP_CSRRW, 32'h0000_ABCD, 32'h0000_BEEF, "stall_wr");
        stall = 1'b0;
        csr(1, 0, CSR_MSCRATCH, OP_CSRRS, 32'h0, 32'h0000_BEEF, "stall_scratch");

        // Interrupt priority with MIE=1 and mie=0x888.
        irq_tim = 1'b1; irq_ext = 1'b1;
        csr(1, 0, CSR_MIP, OP_CSRRS, 32'h0, 32'h0000_0880, "mip");
        chk("irq_pending", {31'd0, irq_pending}, 32'h1);
        chk("irq_cause_mei", irq_cause, 32'h8000_000B);
        irq_ext = 1'b0;
        idle();
        chk("irq_cause_mti", irq_cause, 32'h8000_0007);
        irq_sw = 1'b1;
        idle();
        chk("irq_cause_msi", irq_cause, 32'h8000_0003);
        csr(1, 1, CSR_MSTATUS, OP_CSRRCI, 32'h8, 32'h0000_1888, "clr_mie");
        chk("irq_pending_off", {31'd0, irq_pending}, 32'h0);
        chk("irq_cause_off", irq_cause, 32'h0);
        irq_sw = 1'b0; irq_tim = 1'b0;

        // mcycle carry, then a low-half write blocking the carry.
        csr(0, 1, CSR_MCYCLEH, OP_CSRRW, 32'h5, 32'h0, "mcycleh_wr");
        csr(0, 1, CSR_MCYCLE, OP_CSRRW, 32'hFFFF_FFFF, 32'h0, "mcycle_wr");
        csr(1, 0, CSR_MCYCLE, OP_CSRRS, 32'h0, 32'hFFFF_FFFF, "mcycle_ff");
        csr(1, 0, CSR_MCYCLEH, OP_CSRRS, 32'h0, 32'h6, "mcycleh_carry");
        csr(1, 0, CSR_MCYCLE, OP_CSRRS, 32'h0, 32'h1, "mcycle_wrap");
        csr(0, 1, CSR_MCYCLEH, OP_CSRRW, 32'h5, 32'h0, "mcycleh_wr2");
        csr(0, 1, CSR_MCYCLE, OP_CSRRW, 32'hFFFF_FFFF, 32'h0, "mcycle_wr2");
        csr(1, 1, CSR_MCYCLE, OP_CSRRW, 32'h10, 32'hFFFF_FFFF, "mcycle_wr_lo");
        csr(1, 0, CSR_MCYCLEH, OP_CSRRS, 32'h0, 32'h5, "mcycleh_nocarry");
        csr(1, 0, CSR_MCYCLE, OP_CSRRS, 32'h0, 32'h11, "mcycle_after_wr");

        csr(0, 1, CSR_MINSTRET, OP_CSRRW, 32'h0, 32'h0, "minstret_clr");
        retire = 1'b1;
        repeat (3) idle();
        retire = 1'b0;
        csr(1, 0, CSR_MINSTRET, OP_CSRRS, 32'h0, 32'h3, "minstret");

`ifdef CERES_USER_COUNTERS_EN
        user_exp = 32'h100;
`else
        user_exp = 32'h0;
`endif
        csr(0, 1, CSR_MCYCLE, OP_CSRRW, 32'h100, 32'h0, "mcycle_wr3");
        csr(1, 0, CSR_CYCLE, OP_CSRRS, 32'h0, user_exp, "user_cycle");

        // Reset arriving with a write in flight.
        csr(1, 1, CSR_MSCRATCH, OP_CSRRW, 32'h0000_0777, 32'h0000_BEEF, "scratch_777");
        rst = 1'b1;
        csr(1, 1, CSR_MSCRATCH, OP_CSRRW, 32'h0000_0999, 32'h0000_0777, "rst_wr");
        rst = 1'b0;
        csr(1, 0, CSR_MSCRATCH, OP_CSRRS, 32'h0, 32'h0, "rst_scratch");
        csr(1, 0, CSR_MCYCLEH, OP_CSRRS, 32'h0, 32'h0, "rst_mcycleh");
        csr(1, 0, CSR_MSTATUS, OP_CSRRS, 32'h0, 32'h0000_1800, "rst_mstatus");
        csr(1, 0, CSR_MTVEC, OP_CSRRS, 32'h0, 32'h8000_0000, "rst_mtvec");
        chk("rst_mepc", mepc, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
